serial_sample_source: RTL and testbench

- Upstream producer for the 1024-cycle sample/address stage.
- Deserialises an asynchronous serial line (1 start bit, 8 data bits LSB first, 1 stop bit) into bytes.
- Offers each byte on d7_d0 using the dav_/rfd handshake that stage consumes.
- A one-byte holding register absorbs bytes that arrive while the consumer is busy; overrun and framing errors are flagged and held (sticky).

---
 rtl/serial_sample_source.sv | 200 ++++++++++++++++++++
 tb/tb_serial_sample_source.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sample_source.sv
// Serial byte receiver (start, 8 data LSB first, stop) feeding a dav_/rfd consumer
// through a one-byte holding register, with sticky overrun and framing flags.
module serial_sample_source #(
    parameter int unsigned BIT_TICKS = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rfd,
    input  logic       clr_err,
    output logic       dav_,
    output logic [7:0] d7_d0,
    output logic       overrun,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_TICKS - 1);

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_BREAK
    } rx_state_t;

    typedef enum logic {
        H_IDLE,
        H_OFFER
    } hs_state_t;

    logic             r_sync1;
    logic             r_sync2;
    rx_state_t        r_rstate;
    rx_state_t        w_rstate_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bitn;
    logic [2:0]       w_bitn_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             w_done;
    logic             w_ferr_set;

    hs_state_t        r_hstate;
    hs_state_t        w_hstate_nxt;
    logic             w_dav_n_nxt;
    logic [7:0]       w_dout_nxt;
    logic             w_release;

    logic             r_full;
    logic [7:0]       r_hold;
    logic             w_free;
    logic             w_load;
    logic             w_ovr_set;
    logic             w_rxs;

    assign w_rxs = r_sync2;

    // Receiver next-state: CNT counts down to 0 and the sample happens on the 0 cycle
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_cnt_nxt    = r_cnt;
        w_bitn_nxt   = r_bitn;
        w_shift_nxt  = r_shift;
        w_done       = 1'b0;
        w_ferr_set   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (!w_rxs) begin
                    w_cnt_nxt    = HALF_LOAD;
                    w_rstate_nxt = R_START;
                end
            end
            R_START: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (!w_rxs) begin
                    w_cnt_nxt    = BIT_LOAD;
                    w_bitn_nxt   = 3'd0;
                    w_rstate_nxt = R_DATA;
                end else begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            R_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_shift_nxt = {w_rxs, r_shift[7:1]};
                    w_cnt_nxt   = BIT_LOAD;
                    if (r_bitn == 3'd7) begin
                        w_rstate_nxt = R_STOP;
                    end else begin
                        w_bitn_nxt = r_bitn + 3'd1;
                    end
                end
            end
            R_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_rxs) begin
                    w_done       = 1'b1;
                    w_rstate_nxt = R_IDLE;
                end else begin
                    w_ferr_set   = 1'b1;
                    w_rstate_nxt = R_BREAK;
                end
            end
            R_BREAK: begin
                if (w_rxs) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    // Handshake next-state: one offer per rfd high phase, released on rfd low
    always_comb begin
        w_hstate_nxt = r_hstate;
        w_dav_n_nxt  = dav_;
        w_dout_nxt   = d7_d0;
        w_release    = 1'b0;
        case (r_hstate)
            H_IDLE: begin
                if (r_full && rfd) begin
                    w_dout_nxt   = r_hold;
                    w_dav_n_nxt  = 1'b0;
                    w_hstate_nxt = H_OFFER;
                end
            end
            H_OFFER: begin
                if (!rfd) begin
                    w_dav_n_nxt  = 1'b1;
                    w_release    = 1'b1;
                    w_hstate_nxt = H_IDLE;
                end
            end
            default: begin
                w_hstate_nxt = H_IDLE;
            end
        endcase
    end

    // A release on the same edge frees HOLD for an arriving byte
    assign w_free    = !r_full || w_release;
    assign w_load    = w_done && w_free;
    assign w_ovr_set = w_done && !w_free;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rstate  <= R_IDLE;
            r_cnt     <= '0;
            r_bitn    <= 3'd0;
            r_shift   <= 8'h00;
            r_hstate  <= H_IDLE;
            r_full    <= 1'b0;
            r_hold    <= 8'h00;
            dav_      <= 1'b1;
            d7_d0     <= 8'h00;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_sync1  <= rxd;
            r_sync2  <= r_sync1;
            r_rstate <= w_rstate_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bitn   <= w_bitn_nxt;
            r_shift  <= w_shift_nxt;
            r_hstate <= w_hstate_nxt;
            dav_     <= w_dav_n_nxt;
            d7_d0    <= w_dout_nxt;
            if (w_load) begin
                r_full <= 1'b1;
                r_hold <= r_shift;
            end else if (w_release) begin
                r_full <= 1'b0;
            end
            // Setting a flag outranks a simultaneous clear
            if (w_ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (w_ferr_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_sample_source.sv
// Directed bench for serial_sample_source: serial frames in, consumer model on dav_/rfd,
// checks latency, holding/overrun, framing error, glitch rejection, flag clearing and reset.
module tb_serial_sample_source;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rfd = 1'b1;
    logic       clr_err = 1'b0;
    logic       dav_;
    logic [7:0] d7_d0;
    logic       overrun;
    logic       frame_err;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         t_start = 0;
    int         t_offer = 0;
    int         t_release = 0;
    int         busy = 0;
    bit         in_offer = 1'b0;
    bit         unstable = 1'b0;
    logic [7:0] offer_val = 8'h00;
    logic [7:0] q_got[$];

    serial_sample_source #(.BIT_TICKS(16), .CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .rxd       (rxd),
        .rfd       (rfd),
        .clr_err   (clr_err),
        .dav_      (dav_),
        .d7_d0     (d7_d0),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Consumer: drops rfd one cycle into an offer, stays busy 1030 cycles, then raises rfd
    always @(negedge clock) begin
        if (!in_offer && dav_ == 1'b0) begin
            in_offer  = 1'b1;
            t_offer   = cyc;
            offer_val = d7_d0;
            q_got.push_back(d7_d0);
            if (rfd) begin
                rfd  = 1'b0;
                busy = 1030;
            end
        end else begin
            if (in_offer && dav_ == 1'b1) begin
                in_offer  = 1'b0;
                t_release = cyc;
            end else if (in_offer && d7_d0 != offer_val) begin
                unstable = 1'b1;
            end
            if (busy > 0) begin
                busy = busy - 1;
                if (busy == 0) rfd = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] q_at(input int idx);
        if (idx >= 0 && idx < q_got.size()) return 32'(q_got[idx]);
        return 32'hDEAD;
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Start bit, 8 data bits LSB first, then stop level; rxd is left at the stop level
    task automatic send_frame(input logic [7:0] data, input logic stop);
        @(negedge clock);
        rxd = 1'b0;
        t_start = cyc;
        wait_neg(16);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            wait_neg(16);
        end
        rxd = stop;
        wait_neg(16);
    endtask

    int n0;

    initial begin
        wait_neg(3);
        check("rst_dav", 32'(dav_), 32'd1);
        check("rst_data", 32'(d7_d0), 32'h00);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;
        wait_neg(5);

        // Single frame, latency and release timing
        send_frame(8'hA5, 1'b1);
        wait_neg(20);
        check("t1_count", 32'(q_got.size()), 32'd1);
        check("t1_byte", q_at(0), 32'hA5);
        check("t1_latency", 32'(t_offer - t_start), 32'd156);
        check("t1_release", 32'(t_release - t_offer), 32'd1);
        check("t1_stable", 32'(unstable), 32'd0);
        check("t1_data_kept", 32'(d7_d0), 32'hA5);
        check("t1_flags", {30'd0, overrun, frame_err}, 32'd0);
        wait_neg(1100);

        // Busy consumer: second byte held, third dropped; clr_err on the overrun edge
        n0 = q_got.size();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        fork
            send_frame(8'h33, 1'b1);
            begin
                wait_neg(155);
                clr_err = 1'b1;
                wait_neg(1);
                clr_err = 1'b0;
            end
        join
        wait_neg(10);
        check("t2_overrun", 32'(overrun), 32'd1);
        check("t2_ferr", 32'(frame_err), 32'd0);
        check("t2_count_busy", 32'(q_got.size() - n0), 32'd1);
        check("t2_first", q_at(n0), 32'h11);
        check("t2_dav_busy", 32'(dav_), 32'd1);
        check("t2_data_kept", 32'(d7_d0), 32'h11);
        wait_neg(800);
        check("t2_count_after", 32'(q_got.size() - n0), 32'd2);
        check("t2_second", q_at(n0 + 1), 32'h22);
        wait_neg(1100);

        // Framing error followed by a long break, then a good frame
        n0 = q_got.size();
        send_frame(8'h3C, 1'b0);
        wait_neg(100);
        rxd = 1'b1;
        wait_neg(40);
        check("t3_ferr", 32'(frame_err), 32'd1);
        check("t3_no_byte", 32'(q_got.size() - n0), 32'd0);
        check("t3_ovr_sticky", 32'(overrun), 32'd1);
        send_frame(8'h5A, 1'b1);
        wait_neg(20);
        check("t3_count", 32'(q_got.size() - n0), 32'd1);
        check("t3_byte", q_at(n0), 32'h5A);
        check("t3_ferr_sticky", 32'(frame_err), 32'd1);
        wait_neg(1100);

        // clr_err alone clears both flags
        clr_err = 1'b1;
        wait_neg(1);
        clr_err = 1'b0;
        check("t5_clr", {30'd0, overrun, frame_err}, 32'd0);

        // Short glitch is a false start
        n0 = q_got.size();
        rxd = 1'b0;
        wait_neg(4);
        rxd = 1'b1;
        wait_neg(50);
        check("t4_no_byte", 32'(q_got.size() - n0), 32'd0);
        check("t4_flags", {30'd0, overrun, frame_err}, 32'd0);
        send_frame(8'hFF, 1'b1);
        wait_neg(20);
        check("t4_count", 32'(q_got.size() - n0), 32'd1);
        check("t4_byte", q_at(n0), 32'hFF);
        wait_neg(1100);

        // Reset in the middle of data bit 4, then a clean frame
        n0 = q_got.size();
        fork
            send_frame(8'hF0, 1'b1);
            begin
                wait_neg(88);
                reset = 1'b1;
                wait_neg(1);
                check("t6_rst_dav", 32'(dav_), 32'd1);
                check("t6_rst_data", 32'(d7_d0), 32'h00);
                check("t6_rst_flags", {30'd0, overrun, frame_err}, 32'd0);
                reset = 1'b0;
            end
        join
        wait_neg(20);
        check("t6_no_residue", 32'(q_got.size() - n0), 32'd0);
        send_frame(8'h81, 1'b1);
        wait_neg(20);
        check("t6_count", 32'(q_got.size() - n0), 32'd1);
        check("t6_byte", q_at(n0), 32'h81);
        check("t6_data", 32'(d7_d0), 32'h81);
        check("t6_flags", {30'd0, overrun, frame_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
